zero_word_compressor_pipe: RTL and testbench
============================================

Name: zero_word_compressor_pipe

Overview:
- Parametrised successor of the fixed 16×16-bit Compressor.
- Takes one cache line of NUM_WORDS words of WORD_BITS each and produces three results:
  - a per-word non-zero tag;
  - the non-zero words packed toward word 0;
  - the compressed length in words.
- Two-stage elastic pipeline with valid/ready on both sides, plus a per-line bypass mode.
- Sits between the line buffer and the compressed-line writer.

Parameters:
NUM_WORDS, 16, words per line (>=2)
WORD_BITS, 16, bits per word (>=8)
LEN_BITS, 5, width of out_len; must be >= clog2(NUM_WORDS+1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  in_data/in_bypass valid
in_ready  output  1  block can accept a line this cycle
in_data  input  NUM_WORDS*WORD_BITS  raw line; word i = bits [i*WORD_BITS +: WORD_BITS]
in_bypass  input  1  1 = pass line uncompressed
out_valid  output  1  out_* valid
out_ready  input  1  downstream accepts this cycle
out_data  output  NUM_WORDS*WORD_BITS  packed line
out_tag  output  NUM_WORDS  bit i = input word i non-zero
out_len  output  LEN_BITS  number of valid packed words

Behaviour:
- Reset (reset=0, async):
  - out_valid=0, out_data=0, out_tag=0, out_len=0.
  - Both stage-valid flags cleared.
  - in_ready=1 once reset releases.
  - A line in flight when reset asserts is discarded, never emitted.
- Handshakes:
  - Accept when in_valid&in_ready; emit when out_valid&out_ready.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - in_valid may drop without acceptance; nothing is captured.
- Stage 1 (S1), on accept, registers:
  - in_data;
  - in_bypass;
  - tag[i] = |word i (tag forced all-ones if bypass);
  - len = popcount(tag), or NUM_WORDS if bypass.
- Stage 2 (S2), registers S1 into the output registers:
  - Packing, compress mode: out word j = j-th non-zero input word scanning from word 0 upward, for j < len. Words j >= len are 0.
  - Packing, bypass mode: out_data = in_data unchanged.
- Advance rules:
  - s2_free = !out_valid | out_ready.
  - S1→S2 moves when s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free (combinational).
  - Full throughput: one line per cycle when out_ready held 1.
- Latency: accepted at edge N, out_valid=1 after edge N+1 when unstalled, i.e. 2 cycles accept-to-visible.
- Capacity: 2 lines (S1+S2).
  - Both full and out_ready=0 → in_ready=0.
  - Simultaneous emit and accept with both full: S2 loads from S1 and S1 loads the new line in the same edge. No bubble, no loss, no duplication.
- Order is strictly FIFO.
- All-zero line (compress): tag=0, len=0, data=0; still emitted as a line.
- All words non-zero: tag all-ones, len=NUM_WORDS, data = in_data.
- out_len never exceeds NUM_WORDS; no wrap.

Optional Feature:
Macro CPR_STATS_EN.
- Defined: adds the following ports, all reset to 0:
  - stat_clr input 1: synchronous clear, takes priority over increment.
  - stat_lines output 32: +1 per output handshake.
  - stat_words output 32: +out_len per output handshake; bypass lines add NUM_WORDS.
  - Both counters wrap modulo 2^32.
- Not defined: these ports and counters do not exist; the core datapath is identical.

Test Plan:
- All-zero line, compress mode, out_ready=1 → 2 cycles later: out_valid=1, out_tag=16'h0000, out_len=0, out_data=0.
- Input with word0=16'hCDEF, word2=16'h1234, word15=16'hABCD, others 0 → expected output:
  - out_tag=16'h8005, out_len=3;
  - out words 0..2 = CDEF, 1234, ABCD;
  - words 3..15 = 0.
- Same line with in_bypass=1 → out_tag=16'hFFFF, out_len=16, out_data equal to input.
- Back-to-back lines, word i = i+1, with out_ready=1 throughout:
  - in_ready stays 1;
  - one output per cycle, each with tag FFFF and len 16, in order.
- Backpressure:
  - Offer 4 distinct lines with out_ready=0 for 5 cycles → exactly 2 accepted, then in_ready=0.
  - Raise out_ready → all 4 lines emitted in order, none lost or duplicated.
- Mid-stream reset:
  - Drop reset to 0 while out_valid=1 → out_valid=0 immediately, without waiting for a clock.
  - After release, in_ready=1 and the next accepted line appears 2 cycles later.
  - With CPR_STATS_EN defined, stat_lines/stat_words read 0 after reset.

Source files
------------

// File: rtl/zero_word_compressor_pipe.sv
// Two-stage elastic zero-word compressor: tags non-zero words, packs them toward word 0, reports length.
// Optional statistics counters are built when CPR_STATS_EN is defined.
module zero_word_compressor_pipe #(
  parameter int NUM_WORDS = 16,
  parameter int WORD_BITS = 16,
  parameter int LEN_BITS  = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_WORDS*WORD_BITS-1:0] in_data,
  input  logic                           in_bypass,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_WORDS*WORD_BITS-1:0] out_data,
  output logic [NUM_WORDS-1:0]           out_tag,
  output logic [LEN_BITS-1:0]            out_len
`ifdef CPR_STATS_EN
  ,
  input  logic                           stat_clr,
  output logic [31:0]                    stat_lines,
  output logic [31:0]                    stat_words
`endif
);

  localparam int LINE_BITS = NUM_WORDS * WORD_BITS;

  function automatic logic [NUM_WORDS-1:0] f_word_tags(input logic [LINE_BITS-1:0] line);
    logic [NUM_WORDS-1:0] tags;
    tags = {NUM_WORDS{1'b0}};
    for (int i = 0; i < NUM_WORDS; i++) begin
      tags[i] = |line[i*WORD_BITS +: WORD_BITS];
    end
    return tags;
  endfunction

  function automatic logic [LEN_BITS-1:0] f_popcount(input logic [NUM_WORDS-1:0] tags);
    logic [LEN_BITS-1:0] cnt;
    cnt = {LEN_BITS{1'b0}};
    for (int i = 0; i < NUM_WORDS; i++) begin
      cnt = cnt + LEN_BITS'(tags[i]);
    end
    return cnt;
  endfunction

  // Word i lands at the slot equal to the number of tagged words below it.
  function automatic logic [LINE_BITS-1:0] f_pack(input logic [LINE_BITS-1:0] line,
                                                  input logic [NUM_WORDS-1:0] tags);
    logic [LINE_BITS-1:0] packed_line;
    int                   slot;
    packed_line = {LINE_BITS{1'b0}};
    slot        = 0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (tags[i]) begin
        packed_line[slot*WORD_BITS +: WORD_BITS] = line[i*WORD_BITS +: WORD_BITS];
        slot = slot + 1;
      end else begin
        slot = slot;
      end
    end
    return packed_line;
  endfunction

  logic                 r_s1_valid;
  logic [LINE_BITS-1:0] r_s1_data;
  logic                 r_s1_bypass;
  logic [NUM_WORDS-1:0] r_s1_tag;
  logic [LEN_BITS-1:0]  r_s1_len;

  logic                 r_out_valid;
  logic [LINE_BITS-1:0] r_out_data;
  logic [NUM_WORDS-1:0] r_out_tag;
  logic [LEN_BITS-1:0]  r_out_len;

  logic                 w_s2_free;
  logic                 w_s1_adv;
  logic                 w_accept;
  logic                 w_emit;
  logic [NUM_WORDS-1:0] w_in_tag;
  logic [LEN_BITS-1:0]  w_in_len;
  logic [LINE_BITS-1:0] w_s2_data;

  assign w_s2_free = ~r_out_valid | out_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_free;
  assign in_ready  = ~r_s1_valid | w_s2_free;
  assign w_accept  = in_valid & in_ready;
  assign w_emit    = r_out_valid & out_ready;

  // Stage-1 tag and length of the line being offered
  always_comb begin
    w_in_tag = {NUM_WORDS{1'b0}};
    w_in_len = {LEN_BITS{1'b0}};
    if (in_bypass) begin
      w_in_tag = {NUM_WORDS{1'b1}};
      w_in_len = LEN_BITS'(NUM_WORDS);
    end else begin
      w_in_tag = f_word_tags(in_data);
      w_in_len = f_popcount(w_in_tag);
    end
  end

  // Stage-2 packed line derived from the stage-1 registers
  always_comb begin
    w_s2_data = {LINE_BITS{1'b0}};
    if (r_s1_bypass) begin
      w_s2_data = r_s1_data;
    end else begin
      w_s2_data = f_pack(r_s1_data, r_s1_tag);
    end
  end

  // Stage-1 register: loads on accept, empties when its line moves on
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= {LINE_BITS{1'b0}};
      r_s1_bypass <= 1'b0;
      r_s1_tag    <= {NUM_WORDS{1'b0}};
      r_s1_len    <= {LEN_BITS{1'b0}};
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_data   <= in_data;
      r_s1_bypass <= in_bypass;
      r_s1_tag    <= w_in_tag;
      r_s1_len    <= w_in_len;
    end else if (w_s1_adv) begin
      r_s1_valid  <= 1'b0;
    end
  end

  // Output register: holds while stalled, reloads from stage 1 when free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {LINE_BITS{1'b0}};
      r_out_tag   <= {NUM_WORDS{1'b0}};
      r_out_len   <= {LEN_BITS{1'b0}};
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_s2_data;
      r_out_tag   <= r_s1_tag;
      r_out_len   <= r_s1_len;
    end else if (w_emit) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_len   = r_out_len;

`ifdef CPR_STATS_EN
  logic [31:0] r_stat_lines;
  logic [31:0] r_stat_words;

  // Emitted line and word counters; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_lines <= 32'd0;
      r_stat_words <= 32'd0;
    end else if (stat_clr) begin
      r_stat_lines <= 32'd0;
      r_stat_words <= 32'd0;
    end else if (w_emit) begin
      r_stat_lines <= r_stat_lines + 32'd1;
      r_stat_words <= r_stat_words + 32'(r_out_len);
    end
  end

  assign stat_lines = r_stat_lines;
  assign stat_words = r_stat_words;
`endif

endmodule

// File: tb/tb_zero_word_compressor_pipe.sv
// Directed plus randomized bench for zero_word_compressor_pipe against a queue-based reference model.
module tb_zero_word_compressor_pipe;

  localparam int NW = 16;
  localparam int WB = 16;
  localparam int LW = NW * WB;

  typedef struct {
    logic [LW-1:0] data;
    logic [NW-1:0] tag;
    logic [4:0]    len;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_data;
  logic          in_bypass;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_data;
  logic [NW-1:0] out_tag;
  logic [4:0]    out_len;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  logic          prev_stall = 1'b0;
  logic [LW-1:0] prev_data;
  logic [NW-1:0] prev_tag;
  logic [4:0]    prev_len;

  zero_word_compressor_pipe #(.NUM_WORDS(NW), .WORD_BITS(WB), .LEN_BITS(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_len(out_len)
  );

  always #5 clk = ~clk;

  // Reference: collect the non-zero words into a list, lay them out from word 0.
  function automatic exp_t model(input logic [LW-1:0] d, input logic b);
    exp_t e;
    logic [WB-1:0] nz[$];
    e.data = '0;
    e.tag  = '0;
    if (b) begin
      e.data = d;
      e.tag  = '1;
      e.len  = 5'(NW);
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (d[i*WB +: WB] != '0) begin
          e.tag[i] = 1'b1;
          nz.push_back(d[i*WB +: WB]);
        end
      end
      for (int j = 0; j < nz.size(); j++) e.data[j*WB +: WB] = nz[j];
      e.len = 5'(nz.size());
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check outputs, then run through the rising edge.
  task automatic step(input logic v, input logic [LW-1:0] d, input logic b, input logic ordy,
                      output logic acc);
    exp_t e;
    in_valid = v; in_data = d; in_bypass = b; out_ready = ordy;
    #1;
    if (prev_stall) begin
      chk("hold_valid", LW'(out_valid), LW'(1'b1));
      chk("hold_data", out_data, prev_data);
      chk("hold_tag", LW'(out_tag), LW'(prev_tag));
      chk("hold_len", LW'(out_len), LW'(prev_len));
    end
    if (out_valid && out_ready) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_out observed=%h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_tag", LW'(out_tag), LW'(e.tag));
        chk("out_len", LW'(out_len), LW'(e.len));
      end
    end
    acc = v && in_ready;
    if (acc) exp_q.push_back(model(d, b));
    prev_stall = out_valid && !out_ready;
    prev_data = out_data; prev_tag = out_tag; prev_len = out_len;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_lat(input logic [LW-1:0] d, input logic b);
    logic acc;
    step(1'b1, d, b, 1'b1, acc);
    chk("lat_accept", LW'(acc), LW'(1'b1));
    chk("lat_early", LW'(out_valid), LW'(1'b0));
    step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("lat_visible", LW'(out_valid), LW'(1'b1));
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int i = 0; i < NW; i++) d[i*WB +: WB] = ($urandom_range(0, 1) == 1) ? WB'($urandom) : '0;
    return d;
  endfunction

  initial begin
    logic          acc;
    logic [LW-1:0] d;
    logic [LW-1:0] ed;
    logic [LW-1:0] lines[4];
    int            k;
    int            budget;

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", LW'(out_valid), LW'(1'b0));
    chk("rst_data", out_data, '0);
    chk("rst_tag", LW'(out_tag), LW'(16'h0000));
    chk("rst_len", LW'(out_len), LW'(5'd0));
    reset = 1'b1;
    #1 chk("rst_in_ready", LW'(in_ready), LW'(1'b1));
    @(negedge clk);

    // All-zero compress line
    send_lat('0, 1'b0);
    chk("zero_tag", LW'(out_tag), LW'(16'h0000));
    chk("zero_len", LW'(out_len), LW'(5'd0));
    chk("zero_data", out_data, '0);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // Sparse line, then the same line bypassed
    d = '0; d[15:0] = 16'hCDEF; d[47:32] = 16'h1234; d[255:240] = 16'hABCD;
    ed = '0; ed[15:0] = 16'hCDEF; ed[31:16] = 16'h1234; ed[47:32] = 16'hABCD;
    send_lat(d, 1'b0);
    chk("sparse_tag", LW'(out_tag), LW'(16'h8005));
    chk("sparse_len", LW'(out_len), LW'(5'd3));
    chk("sparse_data", out_data, ed);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    send_lat(d, 1'b1);
    chk("byp_tag", LW'(out_tag), LW'(16'hFFFF));
    chk("byp_len", LW'(out_len), LW'(5'd16));
    chk("byp_data", out_data, d);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // Back-to-back full lines at full throughput
    for (int i = 0; i < NW; i++) d[i*WB +: WB] = WB'(i + 1);
    for (int n = 0; n < 6; n++) begin
      step(1'b1, d, 1'b0, 1'b1, acc);
      chk("b2b_accept", LW'(acc), LW'(1'b1));
      if (n >= 1) chk("b2b_out_valid", LW'(out_valid), LW'(1'b1));
      chk("b2b_in_ready", LW'(in_ready), LW'(1'b1));
    end
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // Backpressure: only two lines fit while stalled
    for (int n = 0; n < 4; n++) begin
      lines[n] = rand_line();
      lines[n][15:0] = 16'(n + 1);
    end
    k = 0;
    for (int n = 0; n < 5; n++) begin
      step(1'b1, lines[k], 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_accepted", LW'(k), LW'(2));
    #1 chk("bp_in_ready", LW'(in_ready), LW'(1'b0));
    @(negedge clk);
    budget = 20;
    while (k < 4 && budget > 0) begin
      step(1'b1, lines[k], 1'b0, 1'b1, acc);
      if (acc) k++;
      budget--;
    end
    chk("bp_all_accepted", LW'(k), LW'(4));

    // Randomized traffic with random stalls and bypass
    for (int n = 0; n < 300; n++) begin
      step(($urandom % 4) != 0, rand_line(), ($urandom % 5) == 0, ($urandom % 3) != 0, acc);
    end
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      step(1'b0, '0, 1'b0, 1'b1, acc);
      budget--;
    end
    chk("drain_rand", LW'(exp_q.size()), LW'(0));

    // Mid-stream asynchronous reset
    step(1'b1, rand_line() | LW'(1), 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("mid_pre_valid", LW'(out_valid), LW'(1'b1));
    #2 reset = 1'b0;
    #1;
    chk("mid_valid", LW'(out_valid), LW'(1'b0));
    chk("mid_data", out_data, '0);
    chk("mid_tag", LW'(out_tag), LW'(16'h0000));
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mid_in_ready", LW'(in_ready), LW'(1'b1));
    d = rand_line();
    send_lat(d, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("final_empty", LW'(exp_q.size()), LW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
